// File: rtl/approx_mul_pkg.sv
// Shared types and width helpers for the approximate-multiplier error
// characterization engine.
package approx_mul_pkg;

  typedef enum logic [2:0] {
    IDLE, APPLY, CHECK, DIV, NEXT, DONE
  } state_t;

  localparam int SCALE_DEF = 10000;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  // diff*SCALE must fit: diff < 2^(2W), SCALE < 2^clog2(SCALE+1)
  function automatic int num_w(input int w, input int scale);
    return 2 * w + clog2(scale + 1);
  endfunction

endpackage

// File: rtl/seq_div.sv
// Unsigned restoring divider: one load cycle, then one quotient bit per cycle.
module seq_div
  import approx_mul_pkg::*;
#(
  parameter int NUM_W = 22,
  parameter int DEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             done,
  output logic [NUM_W-1:0] quotient
);

  localparam int CW = clog2(NUM_W + 1);

  logic [DEN_W-1:0] rem_q, rem_d, den_q, den_d;
  logic [NUM_W-1:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [DEN_W:0]   rem_sh;
  logic [DEN_W-1:0] rem_sub;

  always_comb begin
    rem_sh  = {rem_q, quo_q[NUM_W-1]};
    // modular subtract is exact whenever it is selected (result < den)
    rem_sub = rem_sh[DEN_W-1:0] - den_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    den_d   = den_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (start) begin
      rem_d = '0;
      quo_d = num;
      den_d = den;
      cnt_d = CW'(NUM_W);
    end else if (cnt_q != '0) begin
      if (rem_sh >= {1'b0, den_q}) begin
        rem_d = rem_sub;
        quo_d = {quo_q[NUM_W-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[DEN_W-1:0];
        quo_d = {quo_q[NUM_W-2:0], 1'b0};
      end
      cnt_d  = cnt_q - 1'b1;
      done_d = (cnt_q == CW'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      den_q  <= den_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/approx_mul_err_char.sv
// Exhaustive error-characterization controller for a W x W approximate
// multiplier: sweeps every operand pair and accumulates error metrics.
module approx_mul_err_char
  import approx_mul_pkg::*;
#(
  parameter int W       = 4,
  parameter int MUL_LAT = 1,
  parameter int SCALE   = SCALE_DEF,
  parameter int ED_W    = 16,
  parameter int RED_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [W-1:0]     mul_a,
  output logic [W-1:0]     mul_b,
  input  logic [2*W-1:0]   mul_r,
  output logic             busy,
  output logic             done,
  output logic [2*W:0]     err_cnt,
  output logic [ED_W-1:0]  ed_sum,
  output logic [2*W-1:0]   max_err,
  output logic [RED_W-1:0] red_sum,
  output logic [2*W:0]     zero_err_cnt
);

  localparam int P_W   = 2 * W;
  localparam int NUM_W = num_w(W, SCALE);
  localparam int LW    = clog2(MUL_LAT + 1);

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [LW-1:0]    lat_q, lat_d;
  logic [P_W:0]     err_q, err_d, zc_q, zc_d;
  logic [ED_W-1:0]  ed_q, ed_d;
  logic [P_W-1:0]   max_q, max_d;
  logic [RED_W-1:0] red_q, red_d;

  logic [P_W-1:0]   exact, diff;
  logic [NUM_W-1:0] numer, quot;
  logic             div_start, div_done;
  logic [P_W+1:0]   err_inc, zc_inc;
  logic [ED_W:0]    ed_add;
  logic [RED_W:0]   red_add;

  assign exact = P_W'(a_q) * P_W'(b_q);
  assign diff  = (mul_r >= exact) ? (mul_r - exact) : (exact - mul_r);
  assign numer = NUM_W'(diff) * NUM_W'(SCALE);

  // Carry-out of each widened add flags saturation
  assign err_inc = {1'b0, err_q} + (P_W+2)'(1);
  assign zc_inc  = {1'b0, zc_q} + (P_W+2)'(1);
  assign ed_add  = {1'b0, ed_q} + (ED_W+1)'(diff);
  assign red_add = {1'b0, red_q} + (RED_W+1)'(quot);

  seq_div #(.NUM_W(NUM_W), .DEN_W(P_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .num      (numer),
    .den      (exact),
    .done     (div_done),
    .quotient (quot)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    lat_d     = lat_q;
    err_d     = err_q;
    zc_d      = zc_q;
    ed_d      = ed_q;
    max_d     = max_q;
    red_d     = red_q;
    div_start = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        a_d     = '0;
        b_d     = '0;
        err_d   = '0;
        zc_d    = '0;
        ed_d    = '0;
        max_d   = '0;
        red_d   = '0;
        lat_d   = LW'(MUL_LAT);
        state_d = APPLY;
      end
      APPLY: begin
        lat_d = lat_q - 1'b1;
        if (lat_q == LW'(1)) state_d = CHECK;
      end
      CHECK: begin
        state_d = NEXT;
        if (diff != '0) begin
          err_d = err_inc[P_W+1] ? '1 : err_inc[P_W:0];
          ed_d  = ed_add[ED_W] ? '1 : ed_add[ED_W-1:0];
          if (diff > max_q) max_d = diff;
          if (exact == '0) begin
            zc_d = zc_inc[P_W+1] ? '1 : zc_inc[P_W:0];
          end else begin
            div_start = 1'b1;
            state_d   = DIV;
          end
        end
      end
      DIV: if (div_done) begin
        red_d   = red_add[RED_W] ? '1 : red_add[RED_W-1:0];
        state_d = NEXT;
      end
      NEXT: begin
        if (&{a_q, b_q}) begin
          state_d = DONE;
        end else begin
          // {A,B} as one counter gives B-inner, A-outer ordering
          {a_d, b_d} = {a_q, b_q} + (2*W)'(1);
          lat_d      = LW'(MUL_LAT);
          state_d    = APPLY;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      lat_q   <= '0;
      err_q   <= '0;
      zc_q    <= '0;
      ed_q    <= '0;
      max_q   <= '0;
      red_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      lat_q   <= lat_d;
      err_q   <= err_d;
      zc_q    <= zc_d;
      ed_q    <= ed_d;
      max_q   <= max_d;
      red_q   <= red_d;
    end
  end

  assign mul_a        = a_q;
  assign mul_b        = b_q;
  assign busy         = (state_q == APPLY) || (state_q == CHECK) ||
                        (state_q == DIV)   || (state_q == NEXT);
  assign done         = (state_q == DONE);
  assign err_cnt      = err_q;
  assign ed_sum       = ed_q;
  assign max_err      = max_q;
  assign red_sum      = red_q;
  assign zero_err_cnt = zc_q;

endmodule

// File: tb/tb_approx_mul_err_char.sv
// Bench: lookup-table multiplier models checked against a direct metric sum.
module tb_approx_mul_err_char;

  localparam int W     = 4;
  localparam int NUM_W = 2 * W + $clog2(10001);

  logic clk = 1'b0, rst_n = 1'b0, start1 = 1'b0, start3 = 1'b0;
  logic [W-1:0]   a1, b1, a3, b3;
  logic [2*W-1:0] r1 = '0, r3 = '0;
  logic           busy1, done1, busy3, done3;
  logic [2*W:0]   ec1, zc1, ec3, zc3;
  logic [15:0]    ed1, ed3;
  logic [7:0]     mx1, mx3;
  logic [31:0]    red1, red3;
  logic [7:0]     lut [256];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    r1 <= lut[{a1, b1}];
    r3 <= lut[{a3, b3}];
  end

  approx_mul_err_char #(.W(W), .MUL_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .mul_a(a1), .mul_b(b1),
    .mul_r(r1), .busy(busy1), .done(done1), .err_cnt(ec1), .ed_sum(ed1),
    .max_err(mx1), .red_sum(red1), .zero_err_cnt(zc1));

  approx_mul_err_char #(.W(W), .MUL_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .mul_a(a3), .mul_b(b3),
    .mul_r(r3), .busy(busy3), .done(done3), .err_cnt(ec3), .ed_sum(ed3),
    .max_err(mx3), .red_sum(red3), .zero_err_cnt(zc3));

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // 0 exact, 1 constant zero, 2 LSB cleared, 3 LSB forced, 4 random corruption
  task automatic fill(input int mode);
    for (int i = 0; i < 256; i++) begin
      int ex;
      ex = (i / 16) * (i % 16);
      case (mode)
        0: lut[i] = 8'(ex);
        1: lut[i] = 8'd0;
        2: lut[i] = 8'(ex & ~1);
        3: lut[i] = 8'(ex | 1);
        default: lut[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'(ex);
      endcase
    end
  endtask

  task automatic model(input int lat, output longint e, output longint ed,
                       output longint mx, output longint red, output longint zc,
                       output longint cyc);
    e = 0; ed = 0; mx = 0; red = 0; zc = 0;
    cyc = 256 * (lat + 2);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        longint ex, r, d;
        ex = a * b;
        r  = lut[a * 16 + b];
        d  = (r > ex) ? r - ex : ex - r;
        if (d != 0) begin
          e++;
          ed += d;
          if (d > mx) mx = d;
          if (ex == 0) zc++;
          else begin
            red += (d * 10000) / ex;
            cyc += NUM_W + 1;
          end
        end
      end
  endtask

  task automatic sweep(input string tag, input int mode, input bit pulse);
    longint e, ed, mx, red, zc, cyc_exp;
    int cyc;
    bit got;
    fill(mode);
    model(1, e, ed, mx, red, zc, cyc_exp);
    @(negedge clk) start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    chk({tag, "_busy"}, busy1, 1);
    cyc = 0;
    got = 1'b0;
    while (cyc < 20000 && !got) begin
      @(posedge clk);
      #1 cyc++;
      start1 = pulse && (cyc == 50);
      if (done1) got = 1'b1;
    end
    start1 = 1'b0;
    chk({tag, "_done_seen"}, got, 1);
    chk({tag, "_cycles"}, cyc, cyc_exp);
    chk({tag, "_busy_in_done"}, busy1, 0);
    chk({tag, "_err_cnt"}, ec1, e);
    chk({tag, "_ed_sum"}, ed1, ed);
    chk({tag, "_max_err"}, mx1, mx);
    chk({tag, "_red_sum"}, red1, red);
    chk({tag, "_zero_err"}, zc1, zc);
    @(posedge clk);
    #1 chk({tag, "_done_pulse"}, done1, 0);
    chk({tag, "_hold_err"}, ec1, e);
  endtask

  initial begin
    int cyc, nbad, hold0, dn;
    bit got;
    int seq[$];
    longint e, ed, mx, red, zc, cyc_exp;

    fill(0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_err_cnt", ec1, 0);
    chk("rst_ops", {a1, b1}, 0);
    chk("rst_flags", {busy1, done1}, 0);
    chk("rst_red", red1, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    sweep("exact", 0, 1'b0);
    sweep("zero", 1, 1'b0);
    chk("zero_spec_ed", ed1, 14400);
    chk("zero_spec_red", red1, 2250000);
    sweep("lsbclr", 2, 1'b0);
    sweep("lsbset", 3, 1'b0);
    chk("lsbset_spec_zc", zc1, 31);
    sweep("rand0", 4, 1'b0);
    sweep("rand1", 4, 1'b0);
    sweep("busy_start", 3, 1'b1);

    // operand order with a stretched APPLY phase
    fill(0);
    model(3, e, ed, mx, red, zc, cyc_exp);
    @(negedge clk) start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    seq.push_back(int'({a3, b3}));
    hold0 = 1;
    cyc = 0;
    got = 1'b0;
    while (cyc < 20000 && !got) begin
      @(posedge clk);
      #1 cyc++;
      if (done3) got = 1'b1;
      else if (busy3) begin
        if (int'({a3, b3}) != seq[$]) seq.push_back(int'({a3, b3}));
        if ({a3, b3} == 8'd0) hold0++;
      end
    end
    chk("ord_done_seen", got, 1);
    chk("ord_cycles", cyc, cyc_exp);
    chk("ord_len", seq.size(), 256);
    chk("ord_hold0", hold0, 5);
    nbad = 0;
    foreach (seq[i]) if (seq[i] != i) nbad++;
    chk("ord_bad_entries", nbad, 0);
    chk("ord_err_cnt", ec3, 0);

    // reset during pair 100 (A=6, B=4)
    fill(3);
    @(negedge clk) start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    cyc = 0;
    while (cyc < 20000 && {a1, b1} != 8'd100) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("mid_reached_pair100", {a1, b1}, 100);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("mid_err_cnt", ec1, 0);
    chk("mid_ed_sum", ed1, 0);
    chk("mid_ops", {a1, b1}, 0);
    chk("mid_flags", {busy1, done1}, 0);
    dn = 0;
    repeat (3) begin
      @(posedge clk);
      #1 if (done1) dn++;
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1 if (done1 || busy1) dn++;
    end
    chk("mid_no_done", dn, 0);
    chk("mid_red_after", red1, 0);
    chk("mid_zc_after", zc1, 0);

    sweep("fresh", 2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
